// File: rtl/rc5_cipher_ctrl_if.sv
// ----------------------------------------------------------------------------
// rc5_cipher_ctrl_if
// Bundles every non-clock signal of rc5_cipher_ctrl: the host key/config
// handshake, the keygen start/ready handshake and subkey read port, and the
// block-in / block-out streams.
//   master : host + keygen side (drives requests, kg_ready, sk_data, out_ready)
//   slave  : rc5_cipher_ctrl (drives readies, keygen controls, sk_idx, results)
// ----------------------------------------------------------------------------
interface rc5_cipher_ctrl_if #(
   parameter int W = 16
);
   logic           key_valid;
   logic           key_ready;
   logic [127:0]   key_in;
   logic [4:0]     rounds_in;
   logic           cfg_err;
   logic           kg_start;
   logic [127:0]   kg_key;
   logic [4:0]     kg_num_rounds;
   logic           kg_ready;
   logic [5:0]     sk_idx;
   logic [W-1:0]   sk_data;
   logic           in_valid;
   logic           in_ready;
   logic           in_decrypt;
   logic [2*W-1:0] in_data;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] out_data;
   logic           key_loaded;

   modport master (
      output key_valid, key_in, rounds_in, kg_ready, sk_data,
             in_valid, in_decrypt, in_data, out_ready,
      input  key_ready, cfg_err, kg_start, kg_key, kg_num_rounds, sk_idx,
             in_ready, out_valid, out_data, key_loaded
   );

   modport slave (
      input  key_valid, key_in, rounds_in, kg_ready, sk_data,
             in_valid, in_decrypt, in_data, out_ready,
      output key_ready, cfg_err, kg_start, kg_key, kg_num_rounds, sk_idx,
             in_ready, out_valid, out_data, key_loaded
   );
endinterface

// File: rtl/rc5_cipher_ctrl.sv
// ----------------------------------------------------------------------------
// rc5_cipher_ctrl
// Scheduler and iterative round engine for RC5 (W-bit words, 2W-bit blocks).
// Latches a key and round count, runs the external keygen through its
// start/ready handshake, then encrypts or decrypts blocks one half-round per
// cycle, reading one subkey per cycle from the keygen table.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   bus       rc5_cipher_ctrl_if.slave: key_valid/key_ready/key_in/rounds_in,
//             cfg_err, kg_start/kg_key/kg_num_rounds/kg_ready,
//             sk_idx/sk_data, in_valid/in_ready/in_decrypt/in_data,
//             out_valid/out_ready/out_data, key_loaded
// ----------------------------------------------------------------------------
module rc5_cipher_ctrl #(
   parameter int W          = 16,
   parameter int MAX_ROUNDS = 16,
   parameter int LGW        = 4
) (
   input  logic             clk,
   input  logic             rst,
   rc5_cipher_ctrl_if.slave bus
);

   typedef enum logic [2:0] {NOKEY, KG_RUN, KEYED, RUN, HOLD} state_t;

   localparam logic [4:0] MAX_R = 5'(MAX_ROUNDS);

   state_t         state_q, state_d;
   logic           kg_start_q, kg_start_d;
   logic           key_loaded_q, key_loaded_d;
   logic           out_valid_q, out_valid_d;
   logic           cfg_err_q, cfg_err_d;
   logic           dec_q, dec_d;
   logic [127:0]   kg_key_q, kg_key_d;
   logic [4:0]     kg_rounds_q, kg_rounds_d;
   logic [W-1:0]   a_q, a_d, b_q, b_d;
   logic [5:0]     k_q, k_d;
   logic [2*W-1:0] out_data_q, out_data_d;

   logic           key_ready, in_ready;
   logic           key_acc, blk_acc;
   logic [5:0]     sk_idx;
   logic [5:0]     k_last;
   logic           last_upd;
   logic [W-1:0]   sk;
   logic [W-1:0]   a_new, b_new;

   function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LGW-1:0] n);
      logic [2*W-1:0] t;
      t = {x, x} << n;
      return t[2*W-1:W];
   endfunction

   function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [LGW-1:0] n);
      logic [2*W-1:0] t;
      t = {x, x} >> n;
      return t[W-1:0];
   endfunction

   assign sk      = bus.sk_data;
   // Highest subkey index T-1 = 2r+1; 2*MAX_ROUNDS+1 fits in 6 bits.
   assign k_last  = {kg_rounds_q, 1'b0} + 6'd1;
   assign last_upd = dec_q ? (k_q == 6'd0) : (k_q == k_last);
   assign key_acc = bus.key_valid && key_ready;
   assign blk_acc = bus.in_valid && in_ready;

   // One half-round: k selects whitening (0/1) or A/B half-round (even/odd).
   always_comb begin
      a_new = a_q;
      b_new = b_q;
      if (!dec_q) begin
         if (k_q == 6'd0)      a_new = a_q + sk;
         else if (k_q == 6'd1) b_new = b_q + sk;
         else if (!k_q[0])     a_new = rotl(a_q ^ b_q, b_q[LGW-1:0]) + sk;
         else                  b_new = rotl(b_q ^ a_q, a_q[LGW-1:0]) + sk;
      end else begin
         if (k_q == 6'd0)      a_new = a_q - sk;
         else if (k_q == 6'd1) b_new = b_q - sk;
         else if (!k_q[0])     a_new = rotr(a_q - sk, b_q[LGW-1:0]) ^ b_q;
         else                  b_new = rotr(b_q - sk, a_q[LGW-1:0]) ^ a_q;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= NOKEY;
         kg_start_q   <= 1'b0;
         key_loaded_q <= 1'b0;
         out_valid_q  <= 1'b0;
         cfg_err_q    <= 1'b0;
         dec_q        <= 1'b0;
         kg_key_q     <= '0;
         kg_rounds_q  <= '0;
         a_q          <= '0;
         b_q          <= '0;
         k_q          <= '0;
         out_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         kg_start_q   <= kg_start_d;
         key_loaded_q <= key_loaded_d;
         out_valid_q  <= out_valid_d;
         cfg_err_q    <= cfg_err_d;
         dec_q        <= dec_d;
         kg_key_q     <= kg_key_d;
         kg_rounds_q  <= kg_rounds_d;
         a_q          <= a_d;
         b_q          <= b_d;
         k_q          <= k_d;
         out_data_q   <= out_data_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d      = state_q;
      kg_start_d   = kg_start_q;
      key_loaded_d = key_loaded_q;
      out_valid_d  = out_valid_q;
      cfg_err_d    = 1'b0;
      dec_d        = dec_q;
      kg_key_d     = kg_key_q;
      kg_rounds_d  = kg_rounds_q;
      a_d          = a_q;
      b_d          = b_q;
      k_d          = k_q;
      out_data_d   = out_data_q;
      unique case (state_q)
         NOKEY, KEYED: begin
            if (key_acc) begin
               kg_key_d = bus.key_in;
               if (bus.rounds_in > MAX_R) begin
                  kg_rounds_d = MAX_R;
                  cfg_err_d   = 1'b1;
               end else begin
                  kg_rounds_d = bus.rounds_in;
               end
               key_loaded_d = 1'b0;
               // A keygen still showing ready from the previous key must see
               // ready drop before it is started again.
               kg_start_d = !bus.kg_ready;
               state_d    = KG_RUN;
            end else if (blk_acc) begin
               a_d     = bus.in_data[W-1:0];
               b_d     = bus.in_data[2*W-1:W];
               dec_d   = bus.in_decrypt;
               k_d     = bus.in_decrypt ? k_last : 6'd0;
               state_d = RUN;
            end
         end
         KG_RUN: begin
            if (kg_start_q) begin
               if (bus.kg_ready) begin
                  kg_start_d   = 1'b0;
                  key_loaded_d = 1'b1;
                  state_d      = KEYED;
               end
            end else begin
               kg_start_d = !bus.kg_ready;
            end
         end
         RUN: begin
            a_d = a_new;
            b_d = b_new;
            if (last_upd) begin
               out_data_d  = {b_new, a_new};
               out_valid_d = 1'b1;
               state_d     = HOLD;
            end else begin
               k_d = dec_q ? (k_q - 6'd1) : (k_q + 6'd1);
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = KEYED;
            end
         end
         default: state_d = NOKEY;
      endcase
   end

   // Output logic
   always_comb begin
      key_ready = ((state_q == NOKEY) || (state_q == KEYED)) && !out_valid_q;
      // A key request takes priority over a block request in the same cycle.
      in_ready  = (state_q == KEYED) && !out_valid_q && !bus.key_valid;
      sk_idx    = (state_q == RUN) ? k_q : 6'd0;
   end

   assign bus.key_ready     = key_ready;
   assign bus.in_ready      = in_ready;
   assign bus.sk_idx        = sk_idx;
   assign bus.cfg_err       = cfg_err_q;
   assign bus.kg_start      = kg_start_q;
   assign bus.kg_key        = kg_key_q;
   assign bus.kg_num_rounds = kg_rounds_q;
   assign bus.out_valid     = out_valid_q;
   assign bus.out_data      = out_data_q;
   assign bus.key_loaded    = key_loaded_q;

endmodule

// File: tb/tb_rc5_cipher_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rc5_cipher_ctrl
// Self-checking bench for rc5_cipher_ctrl. Provides a keygen stub (ready five
// cycles after start, ready lingers a few cycles after start drops) and a
// subkey table that is either the trivial S[k] = k+1 or a real RC5-16 key
// schedule computed here. Results are compared against an RC5 reference
// written as the textbook round loop.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

`define CHK(nm, act, exp) chk(nm, 128'(act), 128'(exp))

module tb_rc5_cipher_ctrl;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rc5_cipher_ctrl_if #(.W(W)) bus();

  rc5_cipher_ctrl #(.W(W), .MAX_ROUNDS(16), .LGW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic        stub_mode;
  logic [15:0] ref_s [0:33];

  assign bus.sk_data = stub_mode ? 16'(bus.sk_idx + 6'd1)
                                 : ((bus.sk_idx < 6'd34) ? ref_s[bus.sk_idx] : 16'h0);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] rl(input logic [15:0] x, input int n);
    int s;
    logic [15:0] y;
    s = n & 15;
    y = (x << s) | (x >> (16 - s));
    return y;
  endfunction

  function automatic logic [15:0] rr(input logic [15:0] x, input int n);
    int s;
    logic [15:0] y;
    s = n & 15;
    y = (x >> s) | (x << (16 - s));
    return y;
  endfunction

  task automatic keygen_ref(input logic [127:0] key, input int r);
    logic [15:0] l [0:7];
    logic [15:0] a, b;
    int t, i, j, n;
    t = 2 * r + 2;
    for (int m = 0; m < 8; m++) l[m] = key[16*m +: 16];
    ref_s[0] = 16'hB7E1;
    for (int m = 1; m < t; m++) ref_s[m] = ref_s[m-1] + 16'h9E37;
    a = '0; b = '0; i = 0; j = 0;
    n = 3 * ((t > 8) ? t : 8);
    for (int m = 0; m < n; m++) begin
      a = rl(ref_s[i] + a + b, 3);
      ref_s[i] = a;
      b = rl(l[j] + a + b, int'(a) + int'(b));
      l[j] = b;
      i = (i + 1) % t;
      j = (j + 1) % 8;
    end
  endtask

  function automatic logic [31:0] enc_ref(input logic [31:0] blk, input int r);
    logic [15:0] a, b;
    a = blk[15:0] + ref_s[0];
    b = blk[31:16] + ref_s[1];
    for (int i = 1; i <= r; i++) begin
      a = rl(a ^ b, int'(b)) + ref_s[2*i];
      b = rl(b ^ a, int'(a)) + ref_s[2*i+1];
    end
    return {b, a};
  endfunction

  function automatic logic [31:0] dec_ref(input logic [31:0] blk, input int r);
    logic [15:0] a, b;
    a = blk[15:0];
    b = blk[31:16];
    for (int i = r; i >= 1; i--) begin
      b = rr(b - ref_s[2*i+1], int'(a)) ^ a;
      a = rr(a - ref_s[2*i], int'(b)) ^ b;
    end
    b = b - ref_s[1];
    a = a - ref_s[0];
    return {b, a};
  endfunction

  // ---------------- keygen stub ----------------
  initial begin : kg_stub
    int cnt, lin;
    logic prev;
    bus.kg_ready = 1'b0;
    cnt = 0; lin = 0; prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.kg_start && !prev) `CHK("kg_start_rise_while_ready", bus.kg_ready, 1'b0);
      prev = bus.kg_start;
      if (bus.kg_start && !bus.kg_ready) begin
        cnt++;
        if (cnt == 5) begin bus.kg_ready = 1'b1; cnt = 0; end
      end else if (!bus.kg_start && bus.kg_ready) begin
        lin++;
        if (lin == 3) begin bus.kg_ready = 1'b0; lin = 0; end
      end else begin
        cnt = 0;
      end
    end
  end

  // ---------------- tasks ----------------
  task automatic load_key(input logic [127:0] key, input logic [4:0] rin);
    int n, hi;
    logic [4:0] r_exp;
    r_exp = (rin > 5'd16) ? 5'd16 : rin;
    @(negedge clk);
    bus.key_valid = 1'b1; bus.key_in = key; bus.rounds_in = rin;
    #1;
    n = 0;
    while (!bus.key_ready && n < 50) begin @(negedge clk); #1; n++; end
    `CHK("key_ready_wait", n < 50, 1'b1);
    @(negedge clk);
    bus.key_valid = 1'b0;
    #1;
    `CHK("cfg_err", bus.cfg_err, rin > 5'd16);
    `CHK("kg_num_rounds", bus.kg_num_rounds, r_exp);
    `CHK("kg_key", bus.kg_key, key);
    `CHK("key_loaded_cleared", bus.key_loaded, 1'b0);
    hi = 0; n = 0;
    while (!bus.key_loaded && n < 100) begin
      if (bus.kg_start) hi++;
      @(negedge clk); #1; n++;
      if (n == 1) `CHK("cfg_err_one_cycle", bus.cfg_err, 1'b0);
    end
    `CHK("key_loaded_set", bus.key_loaded, 1'b1);
    `CHK("kg_start_cycles", hi, 5);
    `CHK("kg_start_dropped", bus.kg_start, 1'b0);
  endtask

  task automatic run_block(input logic dec, input logic [31:0] din, input logic [31:0] exp,
                           input int r, input int hold, output logic [31:0] res);
    int n, lat, t, exp_idx;
    logic ok;
    logic [31:0] held;
    t = 2 * r + 2;
    res = '0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_decrypt = dec; bus.in_data = din;
    #1;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(negedge clk); #1; n++; end
    `CHK("in_ready_wait", n < 50, 1'b1);
    if (n >= 50) begin bus.in_valid = 1'b0; return; end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    ok = 1'b1; lat = 0;
    while (!bus.out_valid && lat < 40) begin
      exp_idx = dec ? (t - 1 - lat) : lat;
      if (bus.sk_idx !== 6'(exp_idx)) ok = 1'b0;
      @(negedge clk); #1; lat++;
    end
    `CHK("sk_idx_sequence", ok, 1'b1);
    `CHK("latency", lat, t);
    `CHK("out_data", bus.out_data, exp);
    held = bus.out_data;
    ok = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); #1;
      if (bus.out_data !== held || !bus.out_valid || bus.in_ready) ok = 1'b0;
    end
    if (hold > 0) `CHK("backpressure_stable", ok, 1'b1);
    res = bus.out_data;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    `CHK("out_valid_cleared", bus.out_valid, 1'b0);
    `CHK("sk_idx_idle", bus.sk_idx, 6'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  typedef struct {
    logic        dec;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  initial begin : main
    vec_t         vecs [4];
    logic [127:0] k0, kr;
    logic [31:0]  din, ct, pt, res;
    logic [4:0]   rin;
    int           reff, n;
    logic         ok;

    vecs[0] = '{1'b0, 32'h20001000, 32'h20021001};
    vecs[1] = '{1'b1, 32'h20021001, 32'h20001000};
    vecs[2] = '{1'b0, 32'hFFFFFFFF, 32'h00010000};
    vecs[3] = '{1'b1, 32'h00000000, 32'hFFFEFFFF};
    k0 = 128'h000102030405060708090A0B0C0D0E0F;

    rst = 1'b1;
    stub_mode = 1'b1;
    bus.key_valid = 1'b0; bus.key_in = '0; bus.rounds_in = '0;
    bus.in_valid = 1'b0; bus.in_decrypt = 1'b0; bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    `CHK("rst_key_ready", bus.key_ready, 1'b1);
    `CHK("rst_in_ready", bus.in_ready, 1'b0);
    `CHK("rst_kg_start", bus.kg_start, 1'b0);
    `CHK("rst_key_loaded", bus.key_loaded, 1'b0);
    `CHK("rst_out_valid", bus.out_valid, 1'b0);
    `CHK("rst_cfg_err", bus.cfg_err, 1'b0);
    `CHK("rst_out_data", bus.out_data, 32'h0);
    `CHK("rst_kg_key", bus.kg_key, 128'h0);
    `CHK("rst_kg_num_rounds", bus.kg_num_rounds, 5'd0);
    `CHK("rst_sk_idx", bus.sk_idx, 6'd0);
    rst = 1'b0;

    @(negedge clk);
    bus.in_valid = 1'b1;
    #1;
    `CHK("nokey_in_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    `CHK("nokey_no_output", bus.out_valid, 1'b0);

    load_key({$urandom, $urandom, $urandom, $urandom}, 5'd12);
    load_key(k0, 5'd0);
    foreach (vecs[i]) run_block(vecs[i].dec, vecs[i].din, vecs[i].exp, 0, 0, res);

    stub_mode = 1'b0;
    keygen_ref(k0, 12);
    load_key(k0, 5'd12);
    for (int i = 0; i < 2; i++) begin
      din = $urandom;
      run_block(1'b0, din, enc_ref(din, 12), 12, (i == 0) ? 10 : 0, ct);
      run_block(1'b1, ct, din, 12, 0, pt);
    end

    keygen_ref(k0, 16);
    load_key(k0, 5'd20);
    din = $urandom;
    run_block(1'b0, din, enc_ref(din, 16), 16, 2, ct);
    run_block(1'b1, ct, din, 16, 0, pt);

    for (int it = 0; it < 3; it++) begin
      kr = {$urandom, $urandom, $urandom, $urandom};
      rin = 5'($urandom_range(0, 20));
      reff = (rin > 5'd16) ? 16 : int'(rin);
      keygen_ref(kr, reff);
      load_key(kr, rin);
      for (int b = 0; b < 3; b++) begin
        din = $urandom;
        run_block(1'b0, din, enc_ref(din, reff), reff, int'($urandom_range(0, 3)), ct);
        run_block(1'b1, ct, din, reff, 0, pt);
        din = $urandom;
        run_block(1'b1, din, dec_ref(din, reff), reff, int'($urandom_range(0, 3)), pt);
      end
    end

    keygen_ref(k0, 12);
    load_key(k0, 5'd12);
    @(negedge clk);
    bus.key_valid = 1'b1; bus.key_in = k0; bus.rounds_in = 5'd12;
    bus.in_valid = 1'b1; bus.in_decrypt = 1'b0; bus.in_data = 32'h12345678;
    #1;
    `CHK("simul_key_ready", bus.key_ready, 1'b1);
    `CHK("simul_in_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    bus.key_valid = 1'b0; bus.in_valid = 1'b0;
    #1;
    `CHK("simul_key_taken", bus.key_loaded, 1'b0);
    `CHK("simul_no_run", bus.sk_idx, 6'd0);
    n = 0; ok = 1'b1;
    while (!bus.key_loaded && n < 100) begin
      if (bus.out_valid) ok = 1'b0;
      @(negedge clk); #1; n++;
    end
    `CHK("simul_key_done", bus.key_loaded, 1'b1);
    `CHK("simul_block_dropped", ok, 1'b1);
    din = $urandom;
    run_block(1'b0, din, enc_ref(din, 12), 12, 0, ct);

    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_decrypt = 1'b0; bus.in_data = $urandom;
    #1;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    n = 0;
    while (bus.sk_idx != 6'd7 && n < 50) begin @(negedge clk); #1; n++; end
    `CHK("reach_k7", n < 50, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_out_valid: got %0b expected 0", bus.out_valid);
    end
    checks++;
    if (bus.key_loaded !== 1'b0) begin
      errors++;
      $display("FAIL midrst_key_loaded: got %0b expected 0", bus.key_loaded);
    end
    checks++;
    if (bus.kg_start !== 1'b0) begin
      errors++;
      $display("FAIL midrst_kg_start: got %0b expected 0", bus.kg_start);
    end
    `CHK("midrst_key_ready", bus.key_ready, 1'b1);
    `CHK("midrst_in_ready", bus.in_ready, 1'b0);
    `CHK("midrst_sk_idx", bus.sk_idx, 6'd0);
    `CHK("midrst_out_data", bus.out_data, 32'h0);
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        ok = 1'b0;
        $display("FAIL midrst_out_valid_watch: out_valid high %0d cycles after reset", i + 1);
      end
    end
    `CHK("midrst_block_dropped", ok, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
